// File: rtl/rv32_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit FSM encoding.
package rv32_mmio_pkg;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] BAUD_OFF   = 4'h8;

  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVR  = 2;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = TX_IDLE,
    S_START = TX_START,
    S_DATA  = TX_DATA,
    S_STOP  = TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Core data-bus slice seen by the UART: address/strobes/write data in, read data and hit out.
interface uart_tx_mmio_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          hit;

  modport master (output address, read, write, wdata, input rdata, hit);
  modport slave  (input address, read, write, wdata, output rdata, hit);
endinterface

// File: rtl/uart_tx_shifter.sv
// 8N1 serial shifter: takes a byte from the holding register when idle and
// emits start, eight data bits LSB first, and stop, each lasting div+1 clocks.
module uart_tx_shifter
  import rv32_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] div,
  input  logic        load,
  input  logic [7:0]  tx_byte,
  output logic        busy,
  output logic        tx,
  output logic        taken
);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_done;

  // Divider is latched per bit, so a new BAUD_DIV applies from the next bit boundary.
  assign bit_done = (cnt_q >= div_q);

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    taken   = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (load) begin
          taken   = 1'b1;
          shift_d = tx_byte;
          div_d   = div;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          div_d   = div;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          div_d = div;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is registered from the next state so it changes cleanly on the edge.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus decode, holding register, overrun flag and
// baud divider; serialisation is delegated to uart_tx_shifter.
module uart_tx_mmio
  import rv32_mmio_pkg::*;
#(
  parameter int unsigned BASE        = 'h800,
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);

  localparam logic [AW-1:0] BASE_W = AW'(BASE);

  logic [3:0]  off;
  logic        wr_tx, wr_stat, wr_baud;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic        overrun_q;
  logic [15:0] div_q;
  logic        busy, taken;
  logic        unused_bits;

  assign bus.hit = (bus.address[AW-1:4] == BASE_W[AW-1:4]);
  assign off     = {bus.address[3:2], 2'b00};
  assign wr_tx   = bus.hit && bus.write && (off == TXDATA_OFF);
  assign wr_stat = bus.hit && bus.write && (off == STATUS_OFF);
  assign wr_baud = bus.hit && bus.write && (off == BAUD_OFF);

  assign unused_bits = ^{bus.wdata[DW-1:16], bus.address[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      div_q       <= DEFAULT_DIV;
    end else begin
      if (wr_baud) div_q <= bus.wdata[15:0];
      if (wr_stat && bus.wdata[STAT_OVR]) overrun_q <= 1'b0;
      // A write landing on the same edge as the shifter's take still sees the old byte.
      if (wr_tx) begin
        if (hold_full_q) overrun_q   <= 1'b1;
        else             hold_full_q <= 1'b1;
      end
      if (taken) hold_full_q <= 1'b0;
    end
  end

  // NOTE: hold data is deliberately not reset; hold_full qualifies it.
  always_ff @(posedge clk) begin
    if (wr_tx && !hold_full_q) hold_q <= bus.wdata[7:0];
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.hit && bus.read) begin
      case (off)
        STATUS_OFF: begin
          bus.rdata[STAT_BUSY] = busy;
          bus.rdata[STAT_FULL] = hold_full_q;
          bus.rdata[STAT_OVR]  = overrun_q;
        end
        BAUD_OFF: bus.rdata[15:0] = div_q;
        default:  bus.rdata = '0;
      endcase
    end
  end

  uart_tx_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .div     (div_q),
    .load    (hold_full_q),
    .tx_byte (hold_q),
    .busy    (busy),
    .tx      (tx),
    .taken   (taken)
  );

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: randomized bytes and dividers compared
// against an 8N1 waveform model built from bit times.
module tb_uart_tx_mmio;

  localparam logic [31:0] A_TX   = 32'h800;
  localparam logic [31:0] A_ST   = 32'h804;
  localparam logic [31:0] A_BAUD = 32'h808;
  localparam logic [31:0] A_RSV  = 32'h80C;

  logic clk = 1'b0;
  logic reset;
  logic tx;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  logic        h;
  bit          exp_q[$];
  bit          rec_q[$];
  bit          rec_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_mmio_if #(.AW(32), .DW(32)) u_if ();

  uart_tx_mmio #(
    .BASE('h800), .AW(32), .DW(32), .DEFAULT_DIV(16'd433)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if),
    .tx    (tx)
  );

  always @(negedge clk) if (rec_on) rec_q.push_back(tx);

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Model: an 8N1 frame is start(0), data LSB first, stop(1), each held div+1 clocks.
  function automatic void push_frame(input logic [7:0] b, input int div);
    for (int k = 0; k < 10; k++) begin
      bit v;
      v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      repeat (div + 1) exp_q.push_back(v);
    end
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    u_if.address = a;
    u_if.wdata   = d;
    u_if.write   = 1'b1;
    u_if.read    = 1'b0;
    @(posedge clk);
    #1;
    u_if.write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic hh);
    u_if.address = a;
    u_if.read    = 1'b1;
    #1;
    d  = u_if.rdata;
    hh = u_if.hit;
    u_if.read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, want 1", tx); end
    end
    reset = 1'b0;
    @(negedge clk);
    bus_read(A_BAUD, rd, h);
    checks++;
    if (rd !== 32'd433) begin errors++; $display("FAIL reset_baud: got %0d, want 433", rd); end
    bus_read(A_ST, rd, h);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h, want 0", rd); end
    bus_read(A_TX, rd, h);
    checks++;
    if (rd !== 32'd0 || h !== 1'b1) begin
      errors++; $display("FAIL reset_txdata_read: got rdata=%h hit=%b, want 0/1", rd, h);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b, want 1", tx); end
  endtask

  task automatic test_decode();
    int lows;
    bus_read(32'h7FC, rd, h);
    checks++;
    if (h !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL decode_7fc: got hit=%b rdata=%h, want 0/0", h, rd);
    end
    bus_read(32'h810, rd, h);
    checks++;
    if (h !== 1'b0 || rd !== 32'd0) begin
      errors++; $display("FAIL decode_810: got hit=%b rdata=%h, want 0/0", h, rd);
    end
    bus_read(A_RSV, rd, h);
    checks++;
    if (h !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL decode_rsv: got hit=%b rdata=%h, want 1/0", h, rd);
    end
    u_if.address = 32'h806;  // hit is strobe independent; rdata is gated by read
    #1;
    checks++;
    if (u_if.hit !== 1'b1 || u_if.rdata !== 32'd0) begin
      errors++; $display("FAIL decode_noread: got hit=%b rdata=%h, want 1/0", u_if.hit, u_if.rdata);
    end
    bus_write(A_RSV, 32'hFF);
    bus_write(32'h810, 32'h55);
    bus_write(32'h818, 32'h1234);
    bus_write(32'h7F8, 32'h0007);
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL decode_tx_idle: got %0d low cycles, want 0", lows); end
    bus_read(A_ST, rd, h);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL decode_status: got %h, want 0", rd); end
    bus_read(A_BAUD, rd, h);
    checks++;
    if (rd !== 32'd433) begin errors++; $display("FAIL decode_baud: got %0d, want 433", rd); end
  endtask

  task automatic test_frame(input int div, input logic [7:0] b);
    int n, busy_cycles;
    bit exp_busy;
    bus_write(A_BAUD, 32'(div));
    bus_read(A_BAUD, rd, h);
    checks++;
    if (rd !== 32'(div)) begin errors++; $display("FAIL baud_rw: got %0d, want %0d", rd, div); end
    bus_write(A_TX, {24'h0, b});
    exp_q.delete();
    exp_q.push_back(1'b1);
    push_frame(b, div);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    n = exp_q.size();
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_read(A_ST, rd, h);
      if (i == 0) begin
        checks++;
        if (rd[1] !== 1'b1) begin errors++; $display("FAIL frame_hold_full: got %b, want 1", rd[1]); end
      end
      exp_busy = (i >= 1) && (i <= 10 * (div + 1));
      busy_cycles += int'(rd[0]);
      checks++;
      if (tx !== exp_q[i] || rd[0] !== exp_busy) begin
        errors++;
        $display("FAIL frame_bit: byte=%h div=%0d cycle=%0d got tx=%b busy=%b, want tx=%b busy=%b",
                 b, div, i, tx, rd[0], exp_q[i], exp_busy);
      end
    end
    checks++;
    if (busy_cycles != 10 * (div + 1)) begin
      errors++; $display("FAIL frame_busy_len: got %0d, want %0d", busy_cycles, 10 * (div + 1));
    end
  endtask

  task automatic test_back_to_back(input int div);
    logic [7:0] a, b, c;
    int need, w;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    bus_write(A_BAUD, 32'(div));
    bus_write(A_TX, {24'h0, a});
    rec_q.delete();
    rec_on = 1'b1;
    @(posedge clk);
    #1;
    bus_write(A_TX, {24'h0, b});
    bus_write(A_TX, {24'h0, c});
    @(negedge clk);
    bus_read(A_ST, rd, h);
    checks++;
    if (rd !== 32'h7) begin errors++; $display("FAIL b2b_overrun_status: got %h, want 7", rd); end
    bus_write(A_ST, 32'h4);
    bus_read(A_ST, rd, h);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL b2b_overrun_clear: got %h, want 3", rd); end
    exp_q.delete();
    exp_q.push_back(1'b1);
    push_frame(a, div);
    exp_q.push_back(1'b1);
    push_frame(b, div);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    need = exp_q.size();
    for (w = 0; w < 2000 && rec_q.size() < need; w++) @(posedge clk);
    rec_on = 1'b0;
    checks++;
    if (rec_q.size() < need) begin
      errors++; $display("FAIL b2b_timeout: got %0d samples, want %0d", rec_q.size(), need);
    end else begin
      for (int i = 0; i < need; i++) begin
        checks++;
        if (rec_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_bit: bytes=%h,%h div=%0d cycle=%0d got tx=%b, want %b",
                   a, b, div, i, rec_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    int lows;
    a = 8'($urandom);
    bus_write(A_BAUD, 32'd3);
    bus_write(A_TX, {24'h0, a});   // edge N
    @(posedge clk);
    #1;
    bus_write(A_TX, 32'h0F);      // edge N+2, held
    bus_write(A_TX, 32'hF0);      // edge N+3, dropped
    repeat (14) @(posedge clk);   // edge N+17: first cycle of data bit 3
    @(negedge clk);
    bus_read(A_ST, rd, h);
    checks++;
    if (tx !== a[3] || rd !== 32'h7) begin
      errors++; $display("FAIL mid_before_reset: got tx=%b status=%h, want tx=%b status=7", tx, rd, a[3]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_read(A_ST, rd, h);
    checks++;
    if (tx !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("FAIL mid_after_reset: got tx=%b status=%h, want 1/0", tx, rd);
    end
    bus_read(A_BAUD, rd, h);
    checks++;
    if (rd !== 32'd433) begin errors++; $display("FAIL mid_reset_baud: got %0d, want 433", rd); end
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL mid_no_frame: got %0d low cycles, want 0", lows); end
  endtask

  initial begin
    reset        = 1'b1;
    u_if.address = '0;
    u_if.read    = 1'b0;
    u_if.write   = 1'b0;
    u_if.wdata   = '0;
    test_reset();
    test_decode();
    test_frame(3, 8'h55);
    test_frame(0, 8'h01);
    repeat (4) test_frame(int'($urandom_range(0, 4)), 8'($urandom));
    test_back_to_back(3);
    test_back_to_back(int'($urandom_range(0, 2)));
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data bus, alongside the data memory and downstream of the core's load/store port.
- Consumes the same address/read/write/wdata bus and returns rdata plus a hit flag; the top-level muxes rdata by hit.
- Provides a one-byte holding register, a programmable baud divider, and an 8N1 serial shifter.

Parameters:
- BASE, 'h800, byte base address of the register window; 16-byte aligned.
- AW, 32, address width.
- DW, 32, data width.
- DEFAULT_DIV, 16'd433, reset value of BAUD_DIV; each bit lasts DIV+1 clocks.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  AW  byte address from the core.
- read  input  1  read strobe (MemRead).
- write  input  1  write strobe (MemWrite); sampled at clk edge.
- wdata  input  DW  write data.
- rdata  output  DW  read data; combinational.
- hit  output  1  address within [BASE, BASE+'hF]; combinational, strobe-independent.
- tx  output  1  serial line; idle high.

Behaviour:
- Register map, word offsets; address[1:0] ignored:
  - 0x0 TXDATA: write only; wdata[7:0] loads the holding register; reads return 0.
  - 0x4 STATUS: bit0 busy (FSM != IDLE); bit1 hold_full; bit2 overrun (sticky); others 0. Writing 1 to bit2 clears overrun; other bits are read-only.
  - 0x8 BAUD_DIV: bits[15:0] read/write; upper bits read as 0.
  - 0xC: reserved; reads 0, writes ignored.
- rdata = selected register when hit && read, else 0. No read side effects.
- Reset values: tx=1, hold_full=0, overrun=0, BAUD_DIV=DEFAULT_DIV, FSM=IDLE, baud counter=0, bit index=0. rdata and hit are combinational only.
- TXDATA write behaviour:
  - If hold_full is 0 at the edge: hold<=wdata[7:0], hold_full<=1.
  - If hold_full is 1 at the edge: write dropped, overrun<=1, hold unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_full=1, then shifter<=hold, hold_full<=0, counter<=0, go to START.
  - START: tx=0 for DIV+1 cycles, then go to DATA with bit index 0.
  - DATA: tx=shifter[0], LSB first. Every DIV+1 cycles shift right and increment bit index; after bit 7, go to STOP.
  - STOP: tx=1 for DIV+1 cycles, then go to IDLE.
- A byte written at edge N: hold_full=1 after N, START entered at N+1, tx low from N+1. Frame = 10*(DIV+1) cycles.
- Back-to-back bytes: exactly one IDLE cycle (tx=1) between STOP end and the next START.
- Same edge as the IDLE->START transfer: a TXDATA write sees hold_full=1 and is dropped (overrun set). Software must poll hold_full.
- BAUD_DIV written mid-frame takes effect at the next bit boundary. The counter compares with >= so a lowered DIV never stalls.
- DIV=0 is legal: 1 cycle per bit.
- Reset mid-frame returns to IDLE with tx=1 on the next edge; the held byte is discarded.
- Writes with hit=0 are ignored entirely.

Decomposition:
- Shared package rv32_mmio_pkg holds:
  - register offsets (TXDATA_OFF=0, STATUS_OFF=4, BAUD_OFF=8);
  - STATUS bit indices;
  - tx FSM state encoding (2-bit localparams).
- One natural sub-module: uart_tx_shifter (FSM, baud counter, shifter). Inputs: div, load, byte. Outputs: busy, tx, taken. The top-level keeps bus decode, hold, and overrun.

Test Plan:
- Reset, then read 0x808 -> rdata=433. Read 0x804 -> 0. tx=1 throughout reset and after.
- Write BAUD_DIV=3, then TXDATA=0x55 at edge N:
  - tx=0 over cycles N+1..N+4;
  - then 1,0,1,0,1,0,1,0, each 4 cycles;
  - then stop high;
  - busy=1 for exactly 40 cycles.
- DIV=3; write 0xA5 then 0x3C while busy, then a third write while hold_full=1:
  - both bytes appear on tx with a 1-cycle gap between frames;
  - third write dropped, STATUS=0x7;
  - writing 0x4 to STATUS clears overrun.
- Read of address 0x7FC or 0x810 -> hit=0, rdata=0. Write 0xFF to 0x80C -> no state change.
- Assert reset during DATA bit 3 -> tx=1 the next cycle, STATUS=0, no further frame output.
- DIV=0, TXDATA=0x01 -> tx sequence 0,1,0,0,0,0,0,0,0,1 on consecutive cycles.
